// File: rtl/cv32e40s_pkg.sv
// rtl/cv32e40s_pkg.sv - shared types for the PMP arbiter slice
package cv32e40s_pkg;

  // Privilege levels as encoded in mstatus.MPP
  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } privlvl_t;

  // Access type presented to the PMP checker
  typedef enum logic [1:0] {
    PMP_ACC_READ  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_EXEC  = 2'b10
  } pmp_req_e;

  // Physical address width seen by the PMP checker
  localparam int unsigned PMP_ADDR_W = 34;

  // One requester's view of a PMP check
  typedef struct packed {
    logic [PMP_ADDR_W-1:0] addr;
    pmp_req_e              req_type;
    privlvl_t              priv;
  } pmp_arb_req_t;

  // Which requester owns the checker this cycle
  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_IF   = 2'b01,
    GRANT_LSU  = 2'b10
  } pmp_arb_grant_e;

  // LSU-first selection; a starved IF overrides the LSU
  function automatic pmp_arb_grant_e pmp_arb_select(
    input logic if_elig,
    input logic lsu_elig,
    input logic if_starved
  );
    if (if_elig && (!lsu_elig || if_starved)) begin
      return GRANT_IF;
    end else if (lsu_elig) begin
      return GRANT_LSU;
    end else begin
      return GRANT_NONE;
    end
  endfunction

endpackage

// File: rtl/cv32e40s_pmp_arb_resp_buf.sv
// rtl/cv32e40s_pmp_arb_resp_buf.sv - one-entry valid/ready buffer holding a PMP error bit
module cv32e40s_pmp_arb_resp_buf (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic err_i,
  input  logic resp_ready_i,
  output logic resp_valid_o,
  output logic resp_err_o,
  output logic slot_free_o
);

  logic valid_q;
  logic valid_d;
  logic err_q;
  logic err_d;

  // The slot can take a new result if empty or being drained this cycle
  assign slot_free_o  = !valid_q || resp_ready_i;
  assign resp_valid_o = valid_q;
  assign resp_err_o   = err_q;

  // Load wins over drain so back-to-back checks keep one result per cycle
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    if (load_i) begin
      valid_d = 1'b1;
      err_d   = err_i;
    end else if (valid_q && resp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer state; reset drops any held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/cv32e40s_pmp_arbiter.sv
// rtl/cv32e40s_pmp_arbiter.sv - shares one PMP checker between IF and LSU (option: CV32E40S_PMP_ARB_FAULT_CNT_EN)
module cv32e40s_pmp_arbiter
  import cv32e40s_pkg::*;
#(
  // Cycles IF may be denied while valid before it is forced through (1..15)
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  if_req_valid_i,
  output logic                  if_req_ready_o,
  input  logic [PMP_ADDR_W-1:0] if_req_addr_i,
  input  privlvl_t              if_priv_lvl_i,
  output logic                  if_resp_valid_o,
  input  logic                  if_resp_ready_i,
  output logic                  if_resp_err_o,

  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  input  logic [PMP_ADDR_W-1:0] lsu_req_addr_i,
  input  pmp_req_e              lsu_req_type_i,
  input  privlvl_t              lsu_priv_lvl_i,
  output logic                  lsu_resp_valid_o,
  input  logic                  lsu_resp_ready_i,
  output logic                  lsu_resp_err_o,

  input  logic                  csr_pmp_wr_i,

  output logic [PMP_ADDR_W-1:0] pmp_req_addr_o,
  output pmp_req_e              pmp_req_type_o,
  output privlvl_t              pmp_priv_lvl_o,
  input  logic                  pmp_req_err_i
`ifdef CV32E40S_PMP_ARB_FAULT_CNT_EN
  ,
  input  logic                  fault_cnt_clr_i,
  output logic [15:0]           if_fault_cnt_o,
  output logic [15:0]           lsu_fault_cnt_o
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  pmp_arb_req_t      if_req;
  pmp_arb_req_t      lsu_req;
  pmp_arb_req_t      sel_req;
  pmp_arb_grant_e    grant;

  logic              if_slot_free;
  logic              lsu_slot_free;
  logic              arb_open;
  logic              if_elig;
  logic              lsu_elig;
  logic              if_starved;
  logic              if_gnt;
  logic              lsu_gnt;

  logic              fence_q;
  logic              fence_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Pack each requester's fields; instruction fetch is always an execute check
  always_comb begin
    if_req  = '{addr: if_req_addr_i,  req_type: PMP_ACC_EXEC,   priv: if_priv_lvl_i};
    lsu_req = '{addr: lsu_req_addr_i, req_type: lsu_req_type_i, priv: lsu_priv_lvl_i};
  end

  // Grants are blocked in reset, in the CSR write cycle and in the cycle after it
  assign arb_open   = rst_n && !csr_pmp_wr_i && !fence_q;
  assign if_elig    = if_req_valid_i  && if_slot_free  && arb_open;
  assign lsu_elig   = lsu_req_valid_i && lsu_slot_free && arb_open;
  assign if_starved = (wait_cnt_q == WAIT_SAT);

  // Pick the single owner of the checker for this cycle
  always_comb begin
    grant = pmp_arb_select(if_elig, lsu_elig, if_starved);
  end

  assign if_gnt          = (grant == GRANT_IF);
  assign lsu_gnt         = (grant == GRANT_LSU);
  assign if_req_ready_o  = if_gnt;
  assign lsu_req_ready_o = lsu_gnt;

  // Checker input mux; IF is the idle default so the checker sees stable fetch traffic
  always_comb begin
    sel_req = if_req;
    if (lsu_gnt) begin
      sel_req = lsu_req;
    end
  end

  assign pmp_req_addr_o = sel_req.addr;
  assign pmp_req_type_o = sel_req.req_type;
  assign pmp_priv_lvl_o = sel_req.priv;

  cv32e40s_pmp_arb_resp_buf u_if_resp_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (if_gnt),
    .err_i        (pmp_req_err_i),
    .resp_ready_i (if_resp_ready_i),
    .resp_valid_o (if_resp_valid_o),
    .resp_err_o   (if_resp_err_o),
    .slot_free_o  (if_slot_free)
  );

  cv32e40s_pmp_arb_resp_buf u_lsu_resp_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (lsu_gnt),
    .err_i        (pmp_req_err_i),
    .resp_ready_i (lsu_resp_ready_i),
    .resp_valid_o (lsu_resp_valid_o),
    .resp_err_o   (lsu_resp_err_o),
    .slot_free_o  (lsu_slot_free)
  );

  // Count only cycles where IF lost arbitration; a full IF buffer or a fence is not starvation
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req_valid_i || if_gnt) begin
      wait_cnt_d = '0;
    end else if (if_elig && (wait_cnt_q != WAIT_SAT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // A CSR write commits at this edge, so the following cycle must also stay quiet
  always_comb begin
    fence_d = csr_pmp_wr_i;
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      fence_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fence_q    <= fence_d;
    end
  end

`ifdef CV32E40S_PMP_ARB_FAULT_CNT_EN
  logic [15:0] if_fault_cnt_q;
  logic [15:0] if_fault_cnt_d;
  logic [15:0] lsu_fault_cnt_q;
  logic [15:0] lsu_fault_cnt_d;

  // Saturating fault counters bumped when a faulting result is captured; clear has priority
  always_comb begin
    if_fault_cnt_d  = if_fault_cnt_q;
    lsu_fault_cnt_d = lsu_fault_cnt_q;
    if (fault_cnt_clr_i) begin
      if_fault_cnt_d  = '0;
      lsu_fault_cnt_d = '0;
    end else begin
      if (if_gnt && pmp_req_err_i && (if_fault_cnt_q != 16'hFFFF)) begin
        if_fault_cnt_d = if_fault_cnt_q + 16'd1;
      end
      if (lsu_gnt && pmp_req_err_i && (lsu_fault_cnt_q != 16'hFFFF)) begin
        lsu_fault_cnt_d = lsu_fault_cnt_q + 16'd1;
      end
    end
  end

  // Fault counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_fault_cnt_q  <= '0;
      lsu_fault_cnt_q <= '0;
    end else begin
      if_fault_cnt_q  <= if_fault_cnt_d;
      lsu_fault_cnt_q <= lsu_fault_cnt_d;
    end
  end

  assign if_fault_cnt_o  = if_fault_cnt_q;
  assign lsu_fault_cnt_o = lsu_fault_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40s_pmp_arbiter.sv
// tb/tb_cv32e40s_pmp_arbiter.sv - self-checking bench for cv32e40s_pmp_arbiter
module tb_cv32e40s_pmp_arbiter;
  import cv32e40s_pkg::*;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid_i = 1'b0;
  logic        if_req_ready_o;
  logic [33:0] if_req_addr_i = '0;
  privlvl_t    if_priv_lvl_i = PRIV_LVL_M;
  logic        if_resp_valid_o;
  logic        if_resp_ready_i = 1'b0;
  logic        if_resp_err_o;
  logic        lsu_req_valid_i = 1'b0;
  logic        lsu_req_ready_o;
  logic [33:0] lsu_req_addr_i = '0;
  pmp_req_e    lsu_req_type_i = PMP_ACC_READ;
  privlvl_t    lsu_priv_lvl_i = PRIV_LVL_M;
  logic        lsu_resp_valid_o;
  logic        lsu_resp_ready_i = 1'b0;
  logic        lsu_resp_err_o;
  logic        csr_pmp_wr_i = 1'b0;
  logic [33:0] pmp_req_addr_o;
  pmp_req_e    pmp_req_type_o;
  privlvl_t    pmp_priv_lvl_o;
  logic        pmp_req_err_i;
`ifdef CV32E40S_PMP_ARB_FAULT_CNT_EN
  logic        fault_cnt_clr_i = 1'b0;
  logic [15:0] if_fault_cnt_o;
  logic [15:0] lsu_fault_cnt_o;
`endif

  logic err_drive = 1'b0;
  logic use_model = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in checker: an arbitrary but deterministic function of all three fields
  function automatic logic fake_pmp(input logic [33:0] a, input pmp_req_e t, input privlvl_t p);
    return a[4] ^ a[9] ^ a[33] ^ (t == PMP_ACC_WRITE) ^ (t == PMP_ACC_EXEC) ^ (p == PRIV_LVL_U);
  endfunction

  assign pmp_req_err_i = use_model ? fake_pmp(pmp_req_addr_o, pmp_req_type_o, pmp_priv_lvl_o) : err_drive;

  cv32e40s_pmp_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req_valid_i   (if_req_valid_i),
    .if_req_ready_o   (if_req_ready_o),
    .if_req_addr_i    (if_req_addr_i),
    .if_priv_lvl_i    (if_priv_lvl_i),
    .if_resp_valid_o  (if_resp_valid_o),
    .if_resp_ready_i  (if_resp_ready_i),
    .if_resp_err_o    (if_resp_err_o),
    .lsu_req_valid_i  (lsu_req_valid_i),
    .lsu_req_ready_o  (lsu_req_ready_o),
    .lsu_req_addr_i   (lsu_req_addr_i),
    .lsu_req_type_i   (lsu_req_type_i),
    .lsu_priv_lvl_i   (lsu_priv_lvl_i),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_ready_i (lsu_resp_ready_i),
    .lsu_resp_err_o   (lsu_resp_err_o),
    .csr_pmp_wr_i     (csr_pmp_wr_i),
    .pmp_req_addr_o   (pmp_req_addr_o),
    .pmp_req_type_o   (pmp_req_type_o),
    .pmp_priv_lvl_o   (pmp_priv_lvl_o),
    .pmp_req_err_i    (pmp_req_err_i)
`ifdef CV32E40S_PMP_ARB_FAULT_CNT_EN
    ,
    .fault_cnt_clr_i  (fault_cnt_clr_i),
    .if_fault_cnt_o   (if_fault_cnt_o),
    .lsu_fault_cnt_o  (lsu_fault_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Table record: in = {if_v, lsu_v, if_rr, lsu_rr, wr, err}, ex = {if_rdy, lsu_rdy, if_rv, if_err, lsu_rv, lsu_err}
  typedef struct {
    logic [5:0] in;
    logic [5:0] ex;
    pmp_req_e   lsu_t;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input logic [5:0] ex, input pmp_req_e t);
    vec_t v;
    v.in = in;
    v.ex = ex;
    v.lsu_t = t;
    return v;
  endfunction

  task automatic idle_inputs();
    if_req_valid_i   = 1'b0;
    lsu_req_valid_i  = 1'b0;
    if_resp_ready_i  = 1'b0;
    lsu_resp_ready_i = 1'b0;
    csr_pmp_wr_i     = 1'b0;
    err_drive        = 1'b0;
  endtask

  // Reset with both requesters asserting valid: ready must stay low while in reset
  task automatic do_reset();
    idle_inputs();
    if_req_valid_i  = 1'b1;
    lsu_req_valid_i = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ready", if_req_ready_o, 0);
    chk("rst_lsu_ready", lsu_req_ready_o, 0);
    chk("rst_if_rvalid", if_resp_valid_o, 0);
    chk("rst_lsu_rvalid", lsu_resp_valid_o, 0);
    chk("rst_if_err", if_resp_err_o, 0);
    chk("rst_lsu_err", lsu_resp_err_o, 0);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  vec_t vt[14];

  // Reference model state
  bit m_if_v, m_if_e, m_lsu_v, m_lsu_e, m_fence;
  int m_wait;

  initial begin
    logic [33:0] a_if, a_lsu, e_addr;
    pmp_req_e e_type;
    privlvl_t e_priv;
    bit if_free, lsu_free, open, if_el, lsu_el, g_if, g_lsu;

    vt[0]  = mk(6'b100000, 6'b101000, PMP_ACC_READ);
    vt[1]  = mk(6'b011001, 6'b010011, PMP_ACC_WRITE);
    vt[2]  = mk(6'b111000, 6'b101011, PMP_ACC_READ);
    vt[3]  = mk(6'b111000, 6'b101011, PMP_ACC_READ);
    vt[4]  = mk(6'b111000, 6'b101011, PMP_ACC_READ);
    vt[5]  = mk(6'b111000, 6'b101011, PMP_ACC_READ);
    vt[6]  = mk(6'b111100, 6'b010010, PMP_ACC_READ);
    vt[7]  = mk(6'b111110, 6'b000000, PMP_ACC_READ);
    vt[8]  = mk(6'b111100, 6'b000000, PMP_ACC_READ);
    vt[9]  = mk(6'b111101, 6'b010011, PMP_ACC_READ);
    vt[10] = mk(6'b111100, 6'b010010, PMP_ACC_WRITE);
    vt[11] = mk(6'b111101, 6'b101100, PMP_ACC_READ);
    vt[12] = mk(6'b111100, 6'b010010, PMP_ACC_READ);
    vt[13] = mk(6'b001100, 6'b000000, PMP_ACC_READ);

    // ---------------- directed table ----------------
    do_reset();
    a_if  = 34'h0_0000_1000;
    a_lsu = 34'h2_0000_0040;
    if_req_addr_i  = a_if;
    lsu_req_addr_i = a_lsu;
    if_priv_lvl_i  = PRIV_LVL_U;
    lsu_priv_lvl_i = PRIV_LVL_S;
    for (int i = 0; i < 14; i++) begin
      {if_req_valid_i, lsu_req_valid_i, if_resp_ready_i, lsu_resp_ready_i, csr_pmp_wr_i, err_drive} = vt[i].in;
      lsu_req_type_i = vt[i].lsu_t;
      #2;
      chk($sformatf("tbl%0d_if_ready", i), if_req_ready_o, vt[i].ex[5]);
      chk($sformatf("tbl%0d_lsu_ready", i), lsu_req_ready_o, vt[i].ex[4]);
      chk($sformatf("tbl%0d_pmp_addr", i), pmp_req_addr_o, vt[i].ex[4] ? a_lsu : a_if);
      chk($sformatf("tbl%0d_pmp_type", i), pmp_req_type_o, vt[i].ex[4] ? vt[i].lsu_t : PMP_ACC_EXEC);
      chk($sformatf("tbl%0d_pmp_priv", i), pmp_priv_lvl_o, vt[i].ex[4] ? PRIV_LVL_S : PRIV_LVL_U);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_if_rvalid", i), if_resp_valid_o, vt[i].ex[3]);
      chk($sformatf("tbl%0d_lsu_rvalid", i), lsu_resp_valid_o, vt[i].ex[1]);
      if (vt[i].ex[3]) chk($sformatf("tbl%0d_if_err", i), if_resp_err_o, vt[i].ex[2]);
      if (vt[i].ex[1]) chk($sformatf("tbl%0d_lsu_err", i), lsu_resp_err_o, vt[i].ex[0]);
    end

    // ---------------- asynchronous reset with both buffers full ----------------
    {if_req_valid_i, lsu_req_valid_i, if_resp_ready_i, lsu_resp_ready_i, csr_pmp_wr_i, err_drive} = 6'b110001;
    #2;
    chk("fill_lsu_ready", lsu_req_ready_o, 1);
    @(posedge clk);
    #2;
    chk("fill_if_ready", if_req_ready_o, 1);
    @(posedge clk);
    #1;
    chk("full_if_rvalid", if_resp_valid_o, 1);
    chk("full_lsu_rvalid", lsu_resp_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_if_rvalid", if_resp_valid_o, 0);
    chk("arst_lsu_rvalid", lsu_resp_valid_o, 0);
    chk("arst_if_err", if_resp_err_o, 0);
    chk("arst_lsu_err", lsu_resp_err_o, 0);
    chk("arst_if_ready", if_req_ready_o, 0);
    chk("arst_lsu_ready", lsu_req_ready_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_lsu_ready", lsu_req_ready_o, 1);
    chk("post_rst_if_ready", if_req_ready_o, 0);
    @(posedge clk);
    #1;
    chk("post_rst_lsu_rvalid", lsu_resp_valid_o, 1);
    chk("post_rst_lsu_err", lsu_resp_err_o, 1);

`ifdef CV32E40S_PMP_ARB_FAULT_CNT_EN
    // ---------------- fault counters ----------------
    do_reset();
    chk("fc_rst_if", if_fault_cnt_o, 0);
    if_req_valid_i  = 1'b1;
    if_resp_ready_i = 1'b1;
    err_drive       = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("fc_if_%0d", k), if_fault_cnt_o, k);
    end
    fault_cnt_clr_i = 1'b1;
    #2;
    chk("fc_4th_grant", if_req_ready_o, 1);
    @(posedge clk);
    #1;
    fault_cnt_clr_i = 1'b0;
    chk("fc_if_clr", if_fault_cnt_o, 0);
    chk("fc_lsu", lsu_fault_cnt_o, 0);
`endif

    // ---------------- randomized run against the reference model ----------------
    do_reset();
    use_model = 1'b1;
    m_if_v = 0; m_if_e = 0; m_lsu_v = 0; m_lsu_e = 0; m_fence = 0; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      if_req_valid_i   = ($urandom_range(0, 3) != 0);
      lsu_req_valid_i  = ($urandom_range(0, 3) != 0);
      if_resp_ready_i  = $urandom_range(0, 1);
      lsu_resp_ready_i = $urandom_range(0, 1);
      csr_pmp_wr_i     = ($urandom_range(0, 9) == 0);
      if_req_addr_i    = {2'($urandom_range(0, 3)), 32'($urandom)};
      lsu_req_addr_i   = {2'($urandom_range(0, 3)), 32'($urandom)};
      lsu_req_type_i   = $urandom_range(0, 1) ? PMP_ACC_WRITE : PMP_ACC_READ;
      if_priv_lvl_i    = privlvl_t'($urandom_range(0, 3));
      lsu_priv_lvl_i   = privlvl_t'($urandom_range(0, 3));
      #2;
      if_free  = !m_if_v || if_resp_ready_i;
      lsu_free = !m_lsu_v || lsu_resp_ready_i;
      open     = !csr_pmp_wr_i && !m_fence;
      if_el    = if_req_valid_i && if_free && open;
      lsu_el   = lsu_req_valid_i && lsu_free && open;
      g_if     = if_el && (!lsu_el || m_wait == MAX_WAIT);
      g_lsu    = lsu_el && !g_if;
      e_addr   = g_lsu ? lsu_req_addr_i : if_req_addr_i;
      e_type   = g_lsu ? lsu_req_type_i : PMP_ACC_EXEC;
      e_priv   = g_lsu ? lsu_priv_lvl_i : if_priv_lvl_i;
      chk("rnd_if_ready", if_req_ready_o, g_if);
      chk("rnd_lsu_ready", lsu_req_ready_o, g_lsu);
      chk("rnd_pmp_addr", pmp_req_addr_o, e_addr);
      chk("rnd_pmp_type", pmp_req_type_o, e_type);
      chk("rnd_pmp_priv", pmp_priv_lvl_o, e_priv);
      if (g_if) begin
        m_if_v = 1; m_if_e = fake_pmp(e_addr, e_type, e_priv);
      end else if (if_resp_ready_i) begin
        m_if_v = 0;
      end
      if (g_lsu) begin
        m_lsu_v = 1; m_lsu_e = fake_pmp(e_addr, e_type, e_priv);
      end else if (lsu_resp_ready_i) begin
        m_lsu_v = 0;
      end
      if (!if_req_valid_i || g_if) m_wait = 0;
      else if (if_el && m_wait < MAX_WAIT) m_wait++;
      m_fence = csr_pmp_wr_i;
      @(posedge clk);
      #1;
      chk("rnd_if_rvalid", if_resp_valid_o, m_if_v);
      chk("rnd_lsu_rvalid", lsu_resp_valid_o, m_lsu_v);
      if (m_if_v) chk("rnd_if_err", if_resp_err_o, m_if_e);
      if (m_lsu_v) chk("rnd_lsu_err", lsu_resp_err_o, m_lsu_e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cv32e40s_pmp_arbiter.md
Name: cv32e40s_pmp_arbiter

Overview:
Shares one combinational PMP checker (cv32e40s_pmp) between the instruction-fetch (IF) and load/store (LSU) requesters. Each cycle it grants one requester, drives that requester's address, access type and privilege level to the checker, and captures the error result in a per-requester one-entry response buffer with valid/ready handshake. It applies LSU-first priority with bounded IF starvation, and blocks grants around PMP CSR writes so no check uses half-updated configuration.

Parameters:
MAX_WAIT, 3, consecutive cycles IF may be denied while valid before it gets forced priority (legal range 1..15).
WAIT_W, $clog2(MAX_WAIT+1), width of the starvation counter (derived; not overridden).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
if_req_valid_i  input  1  IF check request
if_req_ready_o  output  1  IF request granted this cycle
if_req_addr_i  input  34  IF physical address
if_priv_lvl_i  input  privlvl_t  IF privilege level
if_resp_valid_o  output  1  IF response buffer full
if_resp_ready_i  input  1  IF consumes response
if_resp_err_o  output  1  IF PMP fault
lsu_req_valid_i  input  1  LSU check request
lsu_req_ready_o  output  1  LSU request granted this cycle
lsu_req_addr_i  input  34  LSU physical address
lsu_req_type_i  input  pmp_req_e  PMP_ACC_READ or PMP_ACC_WRITE
lsu_priv_lvl_i  input  privlvl_t  LSU effective privilege (MPRV-resolved)
lsu_resp_valid_o  output  1  LSU response buffer full
lsu_resp_ready_i  input  1  LSU consumes response
lsu_resp_err_o  output  1  LSU PMP fault
csr_pmp_wr_i  input  1  pulse: a pmpcfg/pmpaddr/mseccfg write commits at the next clock edge
pmp_req_addr_o  output  34  address to checker
pmp_req_type_o  output  pmp_req_e  access type to checker
pmp_priv_lvl_o  output  privlvl_t  privilege to checker
pmp_req_err_i  input  1  checker fault result (combinational)

Behaviour:
- Reset values: all *_ready_o = 0, *_resp_valid_o = 0, *_resp_err_o = 0, starvation counter = 0, fence = 0. pmp_req_* outputs reflect the selection mux (IF defaults: type PMP_ACC_EXEC).
- Slot free for requester X: X_resp_valid_o == 0, or (X_resp_valid_o && X_resp_ready_i) in the same cycle.
- Eligible X: X_req_valid_i && slot free for X && !csr_pmp_wr_i && !fence.
- Grant selection:
  - If both are eligible, LSU wins unless wait_cnt == MAX_WAIT; then IF wins.
  - Exactly one X_req_ready_o is high when any requester is eligible.
  - Request fields are sampled only in the grant cycle. The requester may change them freely when not granted.
- Checker drive: pmp_req_* = granted requester's fields. IF type is always PMP_ACC_EXEC. With no grant, the mux selects IF.
- Response capture:
  - On grant, X_resp_err_o <= pmp_req_err_i and X_resp_valid_o <= 1 at the next edge (latency 1).
  - Held stable until X_resp_ready_i. A drain with no new grant clears valid.
  - A same-cycle drain plus new grant reloads the buffer (back-to-back throughput 1/cycle/requester).
- Starvation counter:
  - Increments (saturating at MAX_WAIT) when if_req_valid_i && IF not granted && IF would otherwise be eligible.
  - Clears on IF grant or when if_req_valid_i is low.
- CSR fence:
  - csr_pmp_wr_i high in cycle N sets fence at the N edge.
  - No grants in N or N+1; grants resume in N+2.
  - A back-to-back wr pulse extends the fence.
  - Responses already buffered are unaffected.
- Asynchronous reset mid-operation drops buffered responses. Requesters must re-issue.

Optional Feature:
Macro CV32E40S_PMP_ARB_FAULT_CNT_EN.
- Defined: adds outputs if_fault_cnt_o[15:0] and lsu_fault_cnt_o[15:0]. Each increments at response capture when the captured err = 1, saturates at 16'hFFFF, resets to 0, and clears synchronously on added input fault_cnt_clr_i (clear wins over increment).
- Undefined: these ports and counters do not exist.

Decomposition:
- cv32e40s_pkg gains struct pmp_arb_req_t {addr[33:0], pmp_req_e type, privlvl_t priv} and the enum pmp_arb_grant_e {GRANT_NONE, GRANT_IF, GRANT_LSU}.
- One sub-module, cv32e40s_pmp_arb_resp_buf (one-entry valid/ready buffer with err bit and slot-free output), instantiated twice.

Test Plan:
- Only IF valid, addr 34'h0_0000_1000, checker err=0 -> if_req_ready_o=1 cycle 0; if_resp_valid_o=1, err=0 in cycle 1; LSU outputs stay 0.
- Both valid continuously, MAX_WAIT=3, all responses drained -> LSU granted cycles 0-2; IF granted cycle 3; counter clears; pattern repeats.
- LSU write, checker err=1, lsu_resp_ready_i=0 for 4 cycles -> lsu_resp_valid_o=1, err=1 held 4 cycles; lsu_req_ready_o=0 meanwhile; IF still granted.
- csr_pmp_wr_i pulse in cycle 5 with both valid -> no grant in cycles 5-6; LSU granted in cycle 7.
- Assert rst_n=0 while both buffers are full -> all outputs 0 immediately (asynchronous); after release, first grant on the next eligible cycle.
- With CV32E40S_PMP_ARB_FAULT_CNT_EN: 3 IF faults, then fault_cnt_clr_i on the same cycle as a 4th fault capture -> if_fault_cnt_o reads 3, then 0.
